// File: rtl/exec_ctrl_pkg.sv
// Shared constants for the NPC execution sequencer: state codes, PC source
// selects and trap codes, plus the PC-select priority helper.
package exec_ctrl_pkg;

  localparam int CtrlStateWidth = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
  localparam logic [1:0] PC_SEL_JAL  = 2'd1;
  localparam logic [1:0] PC_SEL_JALR = 2'd2;

  localparam logic [1:0] TRAP_NONE = 2'd0;
  localparam logic [1:0] TRAP_ILL  = 2'd1;
  localparam logic [1:0] TRAP_IFTO = 2'd2;
  localparam logic [1:0] TRAP_LSTO = 2'd3;

  // jal wins over jalr if a broken decoder ever raises both.
  function automatic logic [1:0] pc_sel_f(input logic is_jal, input logic is_jalr);
    if (is_jal)       return PC_SEL_JAL;
    else if (is_jalr) return PC_SEL_JALR;
    else              return PC_SEL_SEQ;
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Fetch and store handshakes between the sequencer (master) and IFU/LSU (slave).
interface exec_ctrl_if;
  // req is a level raised by the master and held until ack is seen high at a
  // clock edge; ack is a single-cycle pulse and is ignored while req is low.
  logic        ifu_req;
  logic        ifu_ack;
  logic [31:0] ifu_inst;
  logic        lsu_req;
  logic        lsu_ack;

  modport master (output ifu_req, lsu_req, input ifu_ack, ifu_inst, lsu_ack);
  modport slave  (input ifu_req, lsu_req, output ifu_ack, ifu_inst, lsu_ack);
endinterface

// File: rtl/ctrl_watchdog.sv
// Wait-cycle counter shared by the fetch and store waits; expired_o flags the
// last allowed waiting cycle so an ack in that same cycle still wins.
module ctrl_watchdog #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle fetch/decode/store/writeback sequencer for the NPC core.
// Define NPC_PERF_CNT_EN to build the cycle and retired-instruction counters.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  exec_ctrl_if.master               bus,
  output logic [31:0]               ir,
  input  logic                      dec_reg_wen,
  input  logic                      dec_mem_wen,
  input  logic                      dec_is_ebreak,
  input  logic                      dec_inst_not_ipl,
  input  logic                      dec_is_jal,
  input  logic                      dec_is_jalr,
  output logic                      rf_wen,
  output logic                      pc_wen,
  output logic [1:0]                pc_sel,
  output logic                      halt,
  output logic                      trap,
  output logic [1:0]                trap_code,
  output logic [63:0]               cycle_cnt,
  output logic [63:0]               instret_cnt,
  output logic [CtrlStateWidth-1:0] dbg_state
);

  logic [CtrlStateWidth-1:0] state_q, state_d;
  logic [31:0]               ir_q, ir_d;
  logic [1:0]                trap_code_q, trap_code_d;
  logic                      waiting;
  logic                      wd_expired;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);

  // Held clear outside the two wait states, so it restarts at zero on every entry.
  ctrl_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!waiting),
    .en_i      (waiting),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    trap_code_d = trap_code_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.ifu_ack) begin
          ir_d    = bus.ifu_inst;
          state_d = S_DECODE;
        end else if (wd_expired) begin
          trap_code_d = TRAP_IFTO;
          state_d     = S_TRAP;
        end
      end
      S_DECODE: begin
        if (dec_inst_not_ipl) begin
          trap_code_d = TRAP_ILL;
          state_d     = S_TRAP;
        end else if (dec_is_ebreak) begin
          state_d = S_HALT;
        end else if (dec_mem_wen) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.lsu_ack) begin
          state_d = S_WB;
        end else if (wd_expired) begin
          trap_code_d = TRAP_LSTO;
          state_d     = S_TRAP;
        end
      end
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      trap_code_q <= TRAP_NONE;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      trap_code_q <= trap_code_d;
    end
  end

  assign bus.ifu_req = (state_q == S_FETCH);
  assign bus.lsu_req = (state_q == S_MEM);
  assign ir          = ir_q;
  // Decoder inputs are stable in WB because ir does not change there.
  assign rf_wen      = (state_q == S_WB) && dec_reg_wen;
  assign pc_wen      = (state_q == S_WB);
  assign pc_sel      = (state_q == S_WB) ? pc_sel_f(dec_is_jal, dec_is_jalr) : PC_SEL_SEQ;
  assign halt        = (state_q == S_HALT);
  assign trap        = (state_q == S_TRAP);
  assign trap_code   = trap_code_q;
  assign dbg_state   = state_q;

`ifdef NPC_PERF_CNT_EN
  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (state_q == S_WB) instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: IFU/LSU responders plus a toy decoder, a per-program
// timing model feeding an expected queue, and a negedge monitor that drains it.
module tb_exec_ctrl;
  import exec_ctrl_pkg::*;

  localparam int W  = 24;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_ctrl_if bus ();

  logic [31:0] ir;
  logic        dec_reg_wen, dec_mem_wen, dec_is_ebreak, dec_inst_not_ipl, dec_is_jal, dec_is_jalr;
  logic        rf_wen, pc_wen, halt, trap;
  logic [1:0]  pc_sel, trap_code;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [2:0]  dbg_state;

  exec_ctrl #(.TIMEOUT_CYC(TO), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .ir(ir),
    .dec_reg_wen(dec_reg_wen), .dec_mem_wen(dec_mem_wen), .dec_is_ebreak(dec_is_ebreak),
    .dec_inst_not_ipl(dec_inst_not_ipl), .dec_is_jal(dec_is_jal), .dec_is_jalr(dec_is_jalr),
    .rf_wen(rf_wen), .pc_wen(pc_wen), .pc_sel(pc_sel), .halt(halt), .trap(trap),
    .trap_code(trap_code), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .dbg_state(dbg_state)
  );

  // Toy decoder: bit0 writes rd, bit1 stores, bit2 jal, bit3 jalr; two fixed specials.
  always_comb begin
    dec_inst_not_ipl = (ir == 32'hFFFF_FFFF);
    dec_is_ebreak    = (ir == 32'h0010_0073);
    dec_reg_wen      = ir[0];
    dec_mem_wen      = ir[1];
    dec_is_jal       = ir[2];
    dec_is_jalr      = ir[3];
  end

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int cyc;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Item: [23:22] kind (0 writeback, 1 halt, 2 trap), [21:20] pc_sel or trap code,
  // [19] rf_wen, [15:0] cycle index after reset release.
  function automatic logic [W-1:0] mk(input logic [1:0] kind, input logic [1:0] f,
                                      input logic rfw, input int c);
    logic [15:0] c16;
    c16 = c[15:0];
    return {kind, f, rfw, 3'b000, c16};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_item(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event %0h at cycle %0d", name, act, cyc);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", name, act, e);
      end
    end
  endtask

  // Monitor: every writeback and every entry into HALT/TRAP must match the model.
  initial begin
    logic prev_stop;
    prev_stop = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stop = 1'b0;
      end else begin
        if (pc_wen) check_item("wb", mk(2'd0, pc_sel, rf_wen, cyc));
        if ((halt || trap) && !prev_stop)
          check_item("stop", mk(halt ? 2'd1 : 2'd2, trap_code, 1'b0, cyc));
        if (halt || trap) begin
          checks++;
          if (bus.ifu_req || bus.lsu_req || pc_wen || rf_wen || (halt && trap)) begin
            errors++;
            $display("FAIL quiet: activity while stopped at cycle %0d", cyc);
          end
        end
        prev_stop = halt || trap;
      end
    end
  end

  logic [31:0] p_inst[16];
  int p_fd[16];
  int p_ld[16];
  int p_n;
  int ifu_i, ifu_cnt, lsu_cnt;

  // One clock plus responder drive: ack after p_fd/p_ld wait cycles, random stray acks.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.ifu_ack  = 1'b0;
    bus.lsu_ack  = 1'b0;
    bus.ifu_inst = $urandom();
    if (bus.ifu_req) begin
      if (ifu_i < p_n && ifu_cnt == p_fd[ifu_i]) begin
        bus.ifu_ack  = 1'b1;
        bus.ifu_inst = p_inst[ifu_i];
        ifu_i++;
        ifu_cnt = 0;
      end else ifu_cnt++;
    end else begin
      ifu_cnt = 0;
      bus.ifu_ack = ($urandom_range(0, 7) == 0);
    end
    if (bus.lsu_req) begin
      if (ifu_i > 0 && lsu_cnt == p_ld[ifu_i-1]) begin
        bus.lsu_ack = 1'b1;
        lsu_cnt = 0;
      end else lsu_cnt++;
    end else begin
      lsu_cnt = 0;
      bus.lsu_ack = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ifu_ack = 1'b0;
    bus.lsu_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifu_i = 0;
    ifu_cnt = 0;
    lsu_cnt = 0;
    chk("reset_out", {19'd0, ir, bus.ifu_req, bus.lsu_req, rf_wen, pc_wen, pc_sel, halt, trap, trap_code, dbg_state},
        {19'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, PC_SEL_SEQ, 1'b0, 1'b0, TRAP_NONE, S_IDLE});
    chk("reset_cycle_cnt", cycle_cnt, 64'd0);
    chk("reset_instret_cnt", instret_cnt, 64'd0);
  endtask

  // Timing model: IDLE is cycle 0, fetch waits fd+1 cycles, decode 1, a store
  // waits ld+1 cycles, writeback 1; no ack within TO wait cycles means a trap.
  task automatic run_episode(input int extra);
    int t, d, w, stop_c, retired, term, guard;
    logic [31:0] x;
    do_reset();
    t = 1; retired = 0; term = 0; stop_c = 1;
    for (int i = 0; i < p_n && term == 0; i++) begin
      x = p_inst[i];
      if (p_fd[i] >= TO) begin
        exp_q.push_back(mk(2'd2, TRAP_IFTO, 1'b0, t + TO));
        term = 2; stop_c = t + TO;
      end else begin
        d = t + p_fd[i] + 1;
        if (x == 32'hFFFF_FFFF) begin
          exp_q.push_back(mk(2'd2, TRAP_ILL, 1'b0, d + 1));
          term = 2; stop_c = d + 1;
        end else if (x == 32'h0010_0073) begin
          exp_q.push_back(mk(2'd1, TRAP_NONE, 1'b0, d + 1));
          term = 1; stop_c = d + 1;
        end else begin
          w = d + 1;
          if (x[1] && p_ld[i] >= TO) begin
            exp_q.push_back(mk(2'd2, TRAP_LSTO, 1'b0, w + TO));
            term = 2; stop_c = w + TO;
          end else begin
            if (x[1]) w = w + p_ld[i] + 1;
            exp_q.push_back(mk(2'd0, x[2] ? 2'd1 : (x[3] ? 2'd2 : 2'd0), x[0], w));
            retired++;
            t = w + 1;
            stop_c = t;
          end
        end
      end
    end
    if (term != 0) stop_c = stop_c + extra;
    guard = 0;
    while (cyc < stop_c && guard < 2000) begin
      tick();
      guard++;
    end
    chk("episode_bound", guard >= 2000, 1'b0);
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    chk("halt_level", halt, term == 1);
    chk("trap_level", trap, term == 2);
`ifdef NPC_PERF_CNT_EN
    chk("instret", instret_cnt, retired);
    chk("cycles", cycle_cnt, cyc);
`else
    chk("instret", instret_cnt, 64'd0);
    chk("cycles", cycle_cnt, 64'd0);
`endif
  endtask

  task automatic set_inst(input int i, input logic [31:0] x, input int fd, input int ld);
    p_inst[i] = x;
    p_fd[i] = fd;
    p_ld[i] = ld;
  endtask

  initial begin
    int r, guard;
    logic [31:0] x;
    bus.ifu_ack = 1'b0;
    bus.lsu_ack = 1'b0;
    bus.ifu_inst = '0;
    p_n = 0;

    // addi-like with an immediate ack, then a slow store
    p_n = 2; set_inst(0, 32'h1234_5671, 0, 0); set_inst(1, 32'h0000_0A02, 2, 3);
    run_episode(0);
    // jal then jalr, both writing rd; then a nop
    p_n = 3; set_inst(0, 32'h0000_0005, 1, 0); set_inst(1, 32'h0000_0009, 0, 0);
    set_inst(2, 32'h0000_0000, 0, 0);
    run_episode(0);
    // ebreak halts and the illegal instruction behind it is never fetched
    p_n = 3; set_inst(0, 32'h0000_0001, 0, 0); set_inst(1, 32'h0010_0073, 0, 0);
    set_inst(2, 32'hFFFF_FFFF, 0, 0);
    run_episode(100);
    p_n = 1; set_inst(0, 32'hFFFF_FFFF, 0, 0);
    run_episode(10);
    // fetch timeout, then an ack on the last allowed cycle
    p_n = 1; set_inst(0, 32'h0000_0001, TO, 0);
    run_episode(10);
    p_n = 2; set_inst(0, 32'h0000_0001, TO - 1, 0); set_inst(1, 32'h0000_0003, 0, TO - 1);
    run_episode(0);
    // store timeout
    p_n = 1; set_inst(0, 32'h0000_0002, 0, TO + 1);
    run_episode(10);

    for (int e = 0; e < 40; e++) begin
      p_n = $urandom_range(1, 8);
      for (int i = 0; i < p_n; i++) begin
        r = $urandom_range(0, 15);
        if (r == 0)      x = 32'h0010_0073;
        else if (r == 1) x = 32'hFFFF_FFFF;
        else if (r <= 3) x = 32'h0;
        else begin
          x = $urandom();
          x[30] = 1'b0;
          if (x == 32'h0010_0073) x = 32'h0;
        end
        set_inst(i, x,
                 ($urandom_range(0, 19) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1),
                 ($urandom_range(0, 19) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1));
      end
      run_episode(8);
    end

    // reset in the middle of a store wait; a stray ack afterwards is ignored
    p_n = 1; set_inst(0, 32'h0000_0002, 0, TO - 1);
    do_reset();
    guard = 0;
    while (dbg_state != S_MEM && guard < 20) begin
      tick();
      guard++;
    end
    chk("reach_mem", dbg_state, S_MEM);
    tick();
    chk("mem_lsu_req", bus.lsu_req, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.lsu_ack = 1'b1;
    bus.ifu_ack = 1'b0;
    chk("rst_mem_lsu_req", bus.lsu_req, 1'b0);
    chk("rst_mem_state", dbg_state, S_IDLE);
    chk("rst_mem_cycles", cycle_cnt, 64'd0);
    chk("rst_mem_instret", instret_cnt, 64'd0);
    @(posedge clk);
    #1;
    bus.lsu_ack = 1'b0;
    chk("stray_ack_state", dbg_state, S_FETCH);
    chk("stray_ack_lsu_req", bus.lsu_req, 1'b0);
    chk("stray_ack_ir", ir, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
